tcdm_bank_rr_arbiter: RTL and testbench
=======================================

Name: tcdm_bank_rr_arbiter

Overview:
Shares one single-ported TCDM SRAM bank (1-cycle read latency, always ready) between NumReq requesters using round-robin arbitration.
- Grants one request per cycle.
- Drives the bank port.
- Routes the registered response (data, id, valid) back to the requester that won the previous cycle.
- Counts arbitration-conflict cycles for performance profiling.

It sits between the cluster interconnect ports and one bank instance of the TCDM bank wrapper.

Parameters:
NumReq, 4, number of requesters sharing the bank (>=2)
BankSize, 256, words in the bank; bank address width is $clog2(BankSize)
DataWidth, 32, data width
AddrWidth, 32, requester byte-address width
BeWidth, DataWidth/8, byte-enable width
IdWidth, 1, transaction id width
CntWidth, 16, conflict counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NumReq  per-requester request
add_i  in  NumReq*AddrWidth  byte addresses, requester k in slice k
wen_i  in  NumReq  1=read, 0=write (active-low write)
data_i  in  NumReq*DataWidth  write data
be_i  in  NumReq*BeWidth  byte enables
id_i  in  NumReq*IdWidth  transaction ids
gnt_o  out  NumReq  grant, one-hot or zero
r_valid_o  out  NumReq  response valid, one-hot or zero
r_data_o  out  DataWidth  read data, broadcast to all requesters
r_id_o  out  NumReq*IdWidth  response ids
mem_req_o  out  1  bank request
mem_we_o  out  1  bank write enable (active-high)
mem_addr_o  out  $clog2(BankSize)  bank word address
mem_wdata_o  out  DataWidth  bank write data
mem_be_o  out  BeWidth  bank byte enables
mem_rdata_i  in  DataWidth  bank read data, valid one cycle after mem_req_o
cnt_clr_i  in  1  synchronous clear of conflict counter
conflict_cnt_o  out  CntWidth  conflict cycle count

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_ni is asynchronous, active-low.
- Reset values:
  - Priority pointer ptr_q = 0.
  - Response valid register = 0; winner register = 0; id registers = 0.
  - Counter = 0.
  - All gnt_o/r_valid_o = 0.
- Arbitration (combinational, same cycle):
  - Winner w = first index i in the order ptr_q, ptr_q+1, ..., wrapping mod NumReq, with req_i[i]=1.
  - gnt_o[w]=1 and all other grants 0.
  - No request -> gnt_o=0 and mem_req_o=0.
  - The grant does not depend on any earlier cycle's grant; the bank never stalls.
- Pointer update: on any grant, ptr_q <= (w+1) mod NumReq. With no request, ptr_q holds.
- Bank drive:
  - mem_req_o = |req_i.
  - mem_we_o = ~wen_i[w].
  - mem_addr_o = add_i[w][$clog2(BankSize)+1:2]; address bits [1:0] and bits above the bank range are ignored.
  - mem_wdata_o / mem_be_o come from requester w.
  - When mem_req_o=0, the data/address outputs are don't-care but must not be X in simulation; drive requester 0's fields.
- Response (latency exactly 1 cycle after grant):
  - valid_q <= mem_req_o; win_q <= w; id_q <= id_i[w].
  - r_valid_o[win_q] = valid_q; all other bits 0.
  - r_valid_o is asserted for both reads and writes.
  - r_id_o slice win_q = id_q; other slices 0.
  - r_data_o = mem_rdata_i, unregistered passthrough; meaningful only for reads.
- Back-to-back: a new grant every cycle is allowed. Response N and grant N+1 coexist in the same cycle, possibly to the same requester.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NumReq-1,0...; no requester waits more than NumReq-1 cycles.
- Conflict counter:
  - Increments by 1 in each cycle where popcount(req_i) >= 2.
  - Saturates at 2^CntWidth-1 and does not wrap.
  - cnt_clr_i has priority: clear and conflict in the same cycle -> counter = 0.
- Reset mid-operation: the outstanding response is dropped (r_valid_o=0 immediately, asynchronously) and the pointer returns to 0. Requesters must reissue.

Test Plan:
- Single requester: req_i=4'b0100, read, add=0x0000_0010 -> gnt_o=0100 same cycle, mem_addr_o=4, mem_we_o=0; next cycle r_valid_o=0100, r_data_o = bank word 4, r_id_o slice 2 = id sent.
- Write then read: requester 1 writes 0xDEADBEEF be=4'b1111 to word 7, then reads word 7 -> r_valid_o=0010 on both responses; read returns 0xDEADBEEF; be=4'b0011 write of 0x0000_1234 then read -> 0xDEAD1234.
- Full contention: req_i=4'b1111 held for 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3; conflict_cnt_o=8; each r_valid_o one cycle after its grant.
- Pointer skip: ptr at 1, req_i=4'b1001 -> requester 3 wins, next ptr=0; following cycle req_i=4'b1001 -> requester 0 wins.
- Counter saturation/clear: CntWidth=4, 20 conflict cycles -> conflict_cnt_o=15. Then cnt_clr_i=1 together with a conflict -> 0; next conflict cycle -> 1.
- Reset mid-flight: grant to requester 2, assert rst_ni=0 before the next edge -> r_valid_o=0, after release ptr=0 and req_i=4'b1111 grants requester 0.

Source files
------------

// File: rtl/tcdm_bank_rr_arbiter.sv
// tcdm_bank_rr_arbiter: round-robin arbiter sharing one single-ported TCDM bank among NumReq requesters.
module tcdm_bank_rr_arbiter #(
   parameter int NumReq    = 4,
   parameter int BankSize  = 256,
   parameter int DataWidth = 32,
   parameter int AddrWidth = 32,
   parameter int BeWidth   = DataWidth / 8,
   parameter int IdWidth   = 1,
   parameter int CntWidth  = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq*AddrWidth-1:0]   add_i,
   input  logic [NumReq-1:0]             wen_i,
   input  logic [NumReq*DataWidth-1:0]   data_i,
   input  logic [NumReq*BeWidth-1:0]     be_i,
   input  logic [NumReq*IdWidth-1:0]     id_i,
   output logic [NumReq-1:0]             gnt_o,
   output logic [NumReq-1:0]             r_valid_o,
   output logic [DataWidth-1:0]          r_data_o,
   output logic [NumReq*IdWidth-1:0]     r_id_o,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [$clog2(BankSize)-1:0]   mem_addr_o,
   output logic [DataWidth-1:0]          mem_wdata_o,
   output logic [BeWidth-1:0]            mem_be_o,
   input  logic [DataWidth-1:0]          mem_rdata_i,
   input  logic                          cnt_clr_i,
   output logic [CntWidth-1:0]           conflict_cnt_o
);
   localparam int Pw = $clog2(NumReq);
   localparam int Aw = $clog2(BankSize);
   logic [Pw-1:0]       ptr_q, ptr_d, win, win_q;
   logic [IdWidth-1:0]  id_q;
   logic                valid_q, any, conflict;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                unused_add;
   assign unused_add = ^add_i;
   // win stays 0 when nobody requests, so idle bank fields come from requester 0
   always_comb begin
      win = '0;
      for (int o = NumReq - 1; o >= 0; o--) begin
         if (req_i[(int'(ptr_q) + o) % NumReq]) win = Pw'((int'(ptr_q) + o) % NumReq);
      end
   end
   assign any         = |req_i;
   assign conflict    = $countones(req_i) >= 2;
   assign gnt_o       = any ? (NumReq'(1) << win) : '0;
   assign mem_req_o   = any;
   assign mem_we_o    = ~wen_i[win];
   assign mem_addr_o  = add_i[int'(win)*AddrWidth+2 +: Aw];
   assign mem_wdata_o = data_i[int'(win)*DataWidth +: DataWidth];
   assign mem_be_o    = be_i[int'(win)*BeWidth +: BeWidth];
   assign ptr_d       = !any ? ptr_q : (win == Pw'(NumReq - 1)) ? '0 : win + Pw'(1);
   assign cnt_d       = cnt_clr_i ? '0 : (conflict && cnt_q != '1) ? cnt_q + CntWidth'(1) : cnt_q;
   assign r_valid_o   = valid_q ? (NumReq'(1) << win_q) : '0;
   assign r_data_o    = mem_rdata_i;
   assign conflict_cnt_o = cnt_q;
   always_comb begin
      r_id_o = '0;
      if (valid_q) r_id_o[int'(win_q)*IdWidth +: IdWidth] = id_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q   <= '0;
         win_q   <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         win_q   <= win;
         id_q    <= id_i[int'(win)*IdWidth +: IdWidth];
         valid_q <= any;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_tcdm_bank_rr_arbiter.sv
// tb_tcdm_bank_rr_arbiter: directed plus random checks of the bank arbiter against a transaction-level model.
module tb_tcdm_bank_rr_arbiter;
   localparam int N = 4;
   localparam int IW = 2;
   localparam int CW = 4;
   logic          clk_i = 1'b0, rst_ni = 1'b0, cnt_clr = 1'b0;
   logic [N-1:0]  req = '0, wen = '0;
   logic [31:0]   add [N], wdat [N];
   logic [3:0]    be [N];
   logic [IW-1:0] id [N];
   logic [N*32-1:0] add_f, data_f;
   logic [N*4-1:0]  be_f;
   logic [N*IW-1:0] id_f, r_id_o;
   logic [N-1:0]  gnt_o, r_valid_o;
   logic [31:0]   r_data_o, mem_wdata_o, mem_rdata_i;
   logic          mem_req_o, mem_we_o;
   logic [7:0]    mem_addr_o;
   logic [3:0]    mem_be_o;
   logic [CW-1:0] conflict_cnt_o;
   logic [31:0]   bank [256];
   logic [31:0]   ref_mem [256];
   int errs = 0, checks = 0;
   int ptr = 0, cnt = 0, pend_valid = 0, pend_w = 0, pend_read = 0;
   logic [IW-1:0] pend_id;
   logic [31:0]   pend_data;

   tcdm_bank_rr_arbiter #(.NumReq(N), .BankSize(256), .DataWidth(32), .AddrWidth(32),
      .BeWidth(4), .IdWidth(IW), .CntWidth(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .add_i(add_f), .wen_i(wen),
      .data_i(data_f), .be_i(be_f), .id_i(id_f), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
      .r_data_o(r_data_o), .r_id_o(r_id_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .cnt_clr_i(cnt_clr), .conflict_cnt_o(conflict_cnt_o));

   always #5 clk_i = ~clk_i;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         add_f[k*32 +: 32]  = add[k];
         data_f[k*32 +: 32] = wdat[k];
         be_f[k*4 +: 4]     = be[k];
         id_f[k*IW +: IW]   = id[k];
      end
   end

   initial for (int i = 0; i < 256; i++) bank[i] <= 32'hA500_0000 | i;
   always @(posedge clk_i) begin
      if (mem_req_o) begin
         mem_rdata_i <= bank[mem_addr_o];
         if (mem_we_o)
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) bank[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      int w, sel, a, pc;
      #1;
      w = -1;
      for (int o = 0; o < N; o++) if (req[(ptr + o) % N] && w < 0) w = (ptr + o) % N;
      sel = (w < 0) ? 0 : w;
      a = (add[sel] >> 2) % 256;
      chk("gnt", gnt_o, (w < 0) ? 0 : (1 << w));
      chk("mem_req", mem_req_o, w >= 0);
      chk("mem_we", mem_we_o, !wen[sel]);
      chk("mem_addr", mem_addr_o, a);
      chk("mem_wdata", mem_wdata_o, wdat[sel]);
      chk("mem_be", mem_be_o, be[sel]);
      chk("r_valid", r_valid_o, pend_valid ? (1 << pend_w) : 0);
      if (pend_valid) chk("r_id", r_id_o, 64'(pend_id) << (IW * pend_w));
      if (pend_valid && pend_read) chk("r_data", r_data_o, pend_data);
      chk("cnt", conflict_cnt_o, cnt);
      @(posedge clk_i);
      pend_valid = (w >= 0);
      pend_w = sel;
      pend_id = id[sel];
      pend_read = wen[sel];
      pend_data = ref_mem[a];
      if (w >= 0 && !wen[sel])
         for (int b = 0; b < 4; b++) if (be[sel][b]) ref_mem[a][b*8 +: 8] = wdat[sel][b*8 +: 8];
      if (w >= 0) ptr = (w + 1) % N;
      pc = $countones(req);
      cnt = cnt_clr ? 0 : (pc >= 2 && cnt < (1 << CW) - 1) ? cnt + 1 : cnt;
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      chk("rst_r_valid", r_valid_o, 0);
      chk("rst_cnt", conflict_cnt_o, 0);
      rst_ni = 1'b1;
      ptr = 0;
      cnt = 0;
      pend_valid = 0;
   endtask

   task automatic idle_all();
      req = '0;
      wen = '1;
      cnt_clr = 1'b0;
      for (int k = 0; k < N; k++) begin
         add[k] = 32'(k * 4);
         wdat[k] = 32'h1111_1111 * k;
         be[k] = 4'hF;
         id[k] = IW'(k);
      end
   endtask

   task automatic one(input int k, input logic rd, input logic [31:0] ad,
                      input logic [31:0] d, input logic [3:0] b, input logic [IW-1:0] i);
      req = '0;
      req[k] = 1'b1;
      wen[k] = rd;
      add[k] = ad;
      wdat[k] = d;
      be[k] = b;
      id[k] = i;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | i;
      idle_all();
      @(negedge clk_i);
      #2;
      do_reset();
      step();
      one(2, 1'b1, 32'h0000_0010, 32'h0, 4'hF, 2'd3);
      step();
      idle_all();
      step();
      one(1, 1'b0, 32'h0000_001C, 32'hDEAD_BEEF, 4'b1111, 2'd1);
      step();
      one(1, 1'b1, 32'h0000_001C, 32'h0, 4'b1111, 2'd2);
      step();
      one(1, 1'b0, 32'hFFF0_001F, 32'h0000_1234, 4'b0011, 2'd0);
      step();
      one(1, 1'b1, 32'h0000_001C, 32'h0, 4'b1111, 2'd3);
      step();
      idle_all();
      step();
      chk("bank_word7", ref_mem[7], 32'hDEAD_1234);
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 8; c++) step();
      chk("contention_cnt8", conflict_cnt_o, 8);
      idle_all();
      step();
      do_reset();
      req = 4'b0001;
      step();
      req = 4'b1001;
      step();
      chk("skip_ptr", ptr, 0);
      step();
      idle_all();
      step();
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 20; c++) step();
      chk("cnt_sat", conflict_cnt_o, 15);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      step();
      chk("cnt_after_clr", conflict_cnt_o, 1);
      idle_all();
      step();
      do_reset();
      req = 4'b0100;
      step();
      do_reset();
      req = 4'b1111;
      step();
      idle_all();
      for (int c = 0; c < 300; c++) begin
         req = N'($urandom_range(0, (1 << N) - 1));
         wen = N'($urandom_range(0, (1 << N) - 1));
         cnt_clr = ($urandom_range(0, 15) == 0);
         for (int k = 0; k < N; k++) begin
            add[k] = $urandom & 32'hFFFF_FC3F;
            wdat[k] = $urandom;
            be[k] = 4'($urandom_range(0, 15));
            id[k] = IW'($urandom_range(0, (1 << IW) - 1));
         end
         step();
      end
      idle_all();
      step();
      step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
